cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Direct-mapped, write-back cache controller that sequences one cache way (tag, data and valid arrays) and a four-bank memory on behalf of a single CPU port. Hits complete in the request cycle. Misses write back a dirty victim line, fill the line from memory with pipelined reads, then replay the access. It sits between the fetch/memory pipeline stage and the cache arrays plus banked memory.

## Interface
Parameters:
- MEM_LAT, 2, cycles from an accepted memory read to valid m_data_out
- WORDS, 4, 16-bit words per line

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- Addr  in  16  byte address: tag [15:11], index [10:3], offset [2:0]
- DataIn  in  16  write data
- Rd / Wr  in  1 / 1  request strobes, held stable until Done
- DataOut  out  16  read data, valid with Done
- Done  out  1  one-cycle completion pulse
- Stall  out  1  controller busy with a miss
- CacheHit  out  1  with Done: access hit on first compare
- Err  out  1  illegal request
- c_enable, c_comp, c_write, c_valid_in  out  1 each  cache array controls
- c_index  out  8; c_offset  out  3; c_tag_in  out  5; c_data_in  out  16
- c_hit, c_dirty, c_valid  in  1 each; c_tag_out  in  5; c_data_out  in  16
- m_addr  out  16; m_data_in  out  16; m_rd, m_wr  out  1 each
- m_data_out  in  16; m_stall  in  1  request not accepted this cycle

## Operation
- States: IDLE, WB, FILL, DRAIN, RETRY.
- IDLE, with exactly one of Rd or Wr set and Addr[0]=0:
  - Drive c_enable=1, c_comp=1, c_write=Wr, and the Addr fields.
  - If c_hit&c_valid: Done=1, CacheHit=1, DataOut=c_data_out. Stay in IDLE.
  - Else: latch Addr, DataIn, Wr and victim tag c_tag_out. Set Stall=1. Go to WB if c_valid&c_dirty, else FILL. Word counter k=0.
- Err rule: Rd&Wr, or Addr[0]=1, gives Err=1 and Done=1 for one cycle. No array or memory access.
- WB, per word k:
  - Cache read with c_comp=0, c_write=0, c_offset={k,0}.
  - m_wr=1, m_addr={victim_tag,index,k,0}, m_data_in=c_data_out.
  - k advances only when m_stall=0. After k=3 is accepted: k=0, go to FILL.
- FILL: m_rd=1, m_addr={tag,index,k,0}.
  - Each accepted read enters an in-flight pipeline of {valid,k} that is MEM_LAT deep.
  - After k=3 is accepted, go to DRAIN.
- Return write: whenever a pipeline entry exits valid (in FILL or DRAIN), write m_data_out into the cache with c_comp=0, c_write=1, c_valid_in=1, c_tag_in=tag, offset={k_ret,0}.
- DRAIN: wait until the pipeline is empty, then go to RETRY.
- RETRY: compare access c_comp=1, c_write=Wr, with the latched fields. Done=1, CacheHit=0, DataOut=c_data_out. Next state IDLE, Stall=0.
- Write misses merge on RETRY. The line becomes dirty through the array's comp-write path.
- The controller never clears valid bits. Flash clear belongs to the valid array's own rst.

## Timing
- Reset: state IDLE. Pipeline and k cleared. Every output is 0, including DataOut, Stall, Done, Err, all c_* and m_* controls.
- Reset mid-miss: abandon the miss and drop in-flight returns. The partially filled line stays with whatever valid bits it has. No Done is produced.
- Hit latency: Done in the request cycle (cycle 0).
- Clean miss with no m_stall:
  - Reads issued cycles 1–4.
  - Returns written cycles 3–6.
  - RETRY and Done at cycle 7.
- Dirty miss with no m_stall: writebacks cycles 1–4, reads 5–8, returns 7–10, Done at cycle 11.
- m_stall: each cycle it is asserted in WB or FILL adds exactly one cycle. A return exiting the pipeline in the same cycle as a stalled issue is still written.
- Stall is high in all non-IDLE states. Done and Err are never high in the same cycle as Stall rising.

## Configuration
- CACHE_CTRL_STATS_EN defined:
  - Adds outputs hit_cnt and miss_cnt, 16 bits each.
  - hit_cnt increments on each Done with CacheHit=1.
  - miss_cnt increments on each IDLE-to-miss transition.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: the ports and counters are absent.

## Structure
- Package cache_pkg holds:
  - State encoding.
  - Field widths TAG_W=5, IDX_W=8, OFF_W=3.
  - WORDS and MEM_LAT defaults.
  - Address field extract/compose helpers.
- One sub-module, cache_fill_tracker: the MEM_LAT-deep {valid,k} in-flight pipeline with an empty flag.

## Test plan
- Read hit: preload line index 8'h10, read Addr 16'h0080 -> Done and CacheHit at cycle 0, DataOut equals the preloaded word.
- Clean read miss at Addr 16'h1234 with memory word = address -> four m_rd at cycles 1–4 to 0x1230/2/4/6, Done at cycle 7, DataOut 16'h1234, CacheHit=0.
- Dirty write miss evicting tag 5'h03 -> four m_wr to {03,idx,k,0} first, Done at cycle 11, later read hits with the new data.
- m_stall high for 3 cycles mid-FILL -> Done at cycle 10, all four words correct, no duplicate cache writes.
- Rd&Wr together, then Addr=16'h0001 -> Err=1 and Done=1, no m_rd/m_wr/c_write activity. rst asserted in FILL -> outputs 0 next cycle, no Done.
- With CACHE_CTRL_STATS_EN: 3 hits + 2 misses -> hit_cnt=3, miss_cnt=2.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared state encoding, address field widths and address helpers for cache_ctrl
package cache_pkg;
    localparam int TAG_W       = 5;
    localparam int IDX_W       = 8;
    localparam int OFF_W       = 3;
    localparam int WORDS_DEF   = 4;
    localparam int MEM_LAT_DEF = 2;

    typedef enum logic [2:0] {IDLE, WB, FILL, DRAIN, RETRY} state_t;

    function automatic logic [TAG_W-1:0] a_tag(input logic [15:0] a);
        return a[15:11];
    endfunction

    function automatic logic [IDX_W-1:0] a_idx(input logic [15:0] a);
        return a[10:3];
    endfunction

    function automatic logic [OFF_W-1:0] a_off(input logic [15:0] a);
        return a[2:0];
    endfunction

    function automatic logic [OFF_W-1:0] k_off(input logic [OFF_W-2:0] k);
        return {k, 1'b0};
    endfunction

    function automatic logic [15:0] a_make(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] i,
                                           input logic [OFF_W-1:0] o);
        return {t, i, o};
    endfunction
endpackage

// File: rtl/cache_fill_tracker.sv
// cache_fill_tracker: MEM_LAT-deep shift pipeline of in-flight fill reads {valid,k}
module cache_fill_tracker #(
    parameter int MEM_LAT = 2,
    parameter int K_W     = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_push,
    input  logic [K_W-1:0] i_k,
    output logic           o_ret_valid,
    output logic [K_W-1:0] o_ret_k,
    output logic           o_empty
);
    // every stage except the exiting one; empty means nothing remains after this cycle
    localparam logic [MEM_LAT-1:0] KEEP = {MEM_LAT{1'b1}} >> 1;

    logic [MEM_LAT-1:0] r_v;
    logic [K_W-1:0]     r_k [MEM_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= '0;
            for (int i = 0; i < MEM_LAT; i++) r_k[i] <= '0;
        end else begin
            r_v    <= (r_v << 1) | MEM_LAT'(i_push);
            r_k[0] <= i_k;
            for (int i = 1; i < MEM_LAT; i++) r_k[i] <= r_k[i-1];
        end
    end

    assign o_ret_valid = r_v[MEM_LAT-1];
    assign o_ret_k     = r_k[MEM_LAT-1];
    assign o_empty     = ~|(r_v & KEEP);
endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped write-back cache controller (hit in cycle 0, WB/FILL/DRAIN/RETRY on miss)
// Define CACHE_CTRL_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int WORDS   = WORDS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      Addr,
    input  logic [15:0]      DataIn,
    input  logic             Rd,
    input  logic             Wr,
    output logic [15:0]      DataOut,
    output logic             Done,
    output logic             Stall,
    output logic             CacheHit,
    output logic             Err,
    output logic             c_enable,
    output logic             c_comp,
    output logic             c_write,
    output logic             c_valid_in,
    output logic [IDX_W-1:0] c_index,
    output logic [OFF_W-1:0] c_offset,
    output logic [TAG_W-1:0] c_tag_in,
    output logic [15:0]      c_data_in,
    input  logic             c_hit,
    input  logic             c_dirty,
    input  logic             c_valid,
    input  logic [TAG_W-1:0] c_tag_out,
    input  logic [15:0]      c_data_out,
    output logic [15:0]      m_addr,
    output logic [15:0]      m_data_in,
    output logic             m_rd,
    output logic             m_wr,
    input  logic [15:0]      m_data_out,
    input  logic             m_stall
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [15:0]      hit_cnt,
    output logic [15:0]      miss_cnt
`endif
);
    localparam int K_W = OFF_W - 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(WORDS - 1);

    state_t           r_state;
    logic [K_W-1:0]   r_k;
    logic [15:0]      r_addr;
    logic [15:0]      r_data;
    logic             r_wr;
    logic [TAG_W-1:0] r_vtag;
    logic             w_req, w_err, w_hit, w_miss, w_ret_v, w_empty;
    logic [K_W-1:0]   w_ret_k;

    assign w_err  = (Rd & Wr) | ((Rd | Wr) & Addr[0]);
    assign w_req  = (Rd ^ Wr) & ~Addr[0];
    assign w_hit  = c_hit & c_valid;
    assign w_miss = (r_state == IDLE) & w_req & ~w_hit;

    cache_fill_tracker #(.MEM_LAT(MEM_LAT), .K_W(K_W)) u_trk (
        .clk         (clk),
        .rst         (rst),
        .i_push      ((r_state == FILL) & ~m_stall),
        .i_k         (r_k),
        .o_ret_valid (w_ret_v),
        .o_ret_k     (w_ret_k),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_wr    <= 1'b0;
            r_vtag  <= '0;
        end else begin
            unique case (r_state)
                IDLE: if (w_miss) begin
                    r_addr  <= Addr;
                    r_data  <= DataIn;
                    r_wr    <= Wr;
                    r_vtag  <= c_tag_out;
                    r_k     <= '0;
                    r_state <= (c_valid & c_dirty) ? WB : FILL;
                end
                WB, FILL: if (!m_stall) begin
                    r_k <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
                    if (r_k == K_LAST) r_state <= (r_state == WB) ? FILL : DRAIN;
                end
                DRAIN: if (w_empty) r_state <= RETRY;
                RETRY: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // outputs are combinational so hits finish in the request cycle; rst forces them all low
    always_comb begin
        {c_enable, c_comp, c_write, c_valid_in, m_rd, m_wr, Done, CacheHit, Err, Stall} = '0;
        c_index   = '0;
        c_offset  = '0;
        c_tag_in  = '0;
        c_data_in = '0;
        m_addr    = '0;
        m_data_in = '0;
        DataOut   = '0;
        if (!rst) begin
            unique case (r_state)
                IDLE: if (w_err) begin
                    {Err, Done} = 2'b11;
                end else if (w_req) begin
                    {c_enable, c_comp, c_write} = {2'b11, Wr};
                    c_index   = a_idx(Addr);
                    c_offset  = a_off(Addr);
                    c_tag_in  = a_tag(Addr);
                    c_data_in = DataIn;
                    {Done, CacheHit} = {2{w_hit}};
                    DataOut   = w_hit ? c_data_out : '0;
                end
                WB: begin
                    {Stall, c_enable, m_wr} = 3'b111;
                    c_index   = a_idx(r_addr);
                    c_offset  = k_off(r_k);
                    m_addr    = a_make(r_vtag, a_idx(r_addr), k_off(r_k));
                    m_data_in = c_data_out;
                end
                FILL, DRAIN: begin
                    Stall  = 1'b1;
                    m_rd   = (r_state == FILL);
                    m_addr = m_rd ? a_make(a_tag(r_addr), a_idx(r_addr), k_off(r_k)) : '0;
                    if (w_ret_v) begin
                        {c_enable, c_write, c_valid_in} = 3'b111;
                        c_index   = a_idx(r_addr);
                        c_offset  = k_off(w_ret_k);
                        c_tag_in  = a_tag(r_addr);
                        c_data_in = m_data_out;
                    end
                end
                RETRY: begin
                    {Stall, c_enable, c_comp, c_write, Done} = {3'b111, r_wr, 1'b1};
                    c_index   = a_idx(r_addr);
                    c_offset  = a_off(r_addr);
                    c_tag_in  = a_tag(r_addr);
                    c_data_in = r_data;
                    DataOut   = c_data_out;
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] r_hit_cnt, r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (Done && CacheHit && r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 1'b1;
            if (w_miss && r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 1'b1;
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: scoreboard bench for cache_ctrl with behavioural cache arrays and pipelined memory
module tb_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Addr, DataIn, DataOut;
    logic        Rd, Wr, Done, Stall, CacheHit, Err;
    logic        c_enable, c_comp, c_write, c_valid_in;
    logic [7:0]  c_index;
    logic [2:0]  c_offset;
    logic [4:0]  c_tag_in, c_tag_out;
    logic [15:0] c_data_in, c_data_out;
    logic        c_hit, c_dirty, c_valid;
    logic [15:0] m_addr, m_data_in, m_data_out;
    logic        m_rd, m_wr, m_stall;
`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int st_lo = -1;
    int st_hi = -1;
    int fill_wr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always_comb m_stall = (cyc >= st_lo) && (cyc <= st_hi);

    cache_ctrl dut (
        .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .Err(Err),
        .c_enable(c_enable), .c_comp(c_comp), .c_write(c_write), .c_valid_in(c_valid_in),
        .c_index(c_index), .c_offset(c_offset), .c_tag_in(c_tag_in), .c_data_in(c_data_in),
        .c_hit(c_hit), .c_dirty(c_dirty), .c_valid(c_valid), .c_tag_out(c_tag_out),
        .c_data_out(c_data_out), .m_addr(m_addr), .m_data_in(m_data_in), .m_rd(m_rd),
        .m_wr(m_wr), .m_data_out(m_data_out), .m_stall(m_stall)
`ifdef CACHE_CTRL_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    // cache arrays: combinational read, write on clock edge
    logic [4:0]  tg [256];
    logic        vl [256];
    logic        dt [256];
    logic [15:0] dat [256][4];
    logic        arr_clr, pre_en, pre_dirty;
    logic [7:0]  pre_idx;
    logic [4:0]  pre_tag;
    logic [15:0] pre_d;

    always_comb begin
        c_tag_out  = tg[c_index];
        c_valid    = vl[c_index];
        c_dirty    = dt[c_index];
        c_data_out = dat[c_index][c_offset[2:1]];
        c_hit      = c_comp && (tg[c_index] == c_tag_in);
    end

    always @(posedge clk) begin
        if (arr_clr) begin
            for (int i = 0; i < 256; i++) begin
                tg[i] <= '0; vl[i] <= 1'b0; dt[i] <= 1'b0;
                for (int j = 0; j < 4; j++) dat[i][j] <= '0;
            end
        end else if (pre_en) begin
            tg[pre_idx] <= pre_tag; vl[pre_idx] <= 1'b1; dt[pre_idx] <= pre_dirty;
            for (int j = 0; j < 4; j++) dat[pre_idx][j] <= pre_d + 16'(j);
        end else if (c_enable && c_write) begin
            if (!c_comp) begin
                dat[c_index][c_offset[2:1]] <= c_data_in;
                tg[c_index] <= c_tag_in; vl[c_index] <= c_valid_in; dt[c_index] <= 1'b0;
                fill_wr <= fill_wr + 1;
            end else if (vl[c_index] && tg[c_index] == c_tag_in) begin
                dat[c_index][c_offset[2:1]] <= c_data_in;
                dt[c_index] <= 1'b1;
            end
        end
    end

    // memory: unwritten words read back as their own byte address, two-cycle read latency
    logic [15:0] mem [logic [15:0]];
    logic [15:0] p0 = '0, p1 = '0;
    assign m_data_out = p1;

    always @(posedge clk) begin
        p0 <= (m_rd && !m_stall) ? (mem.exists(m_addr) ? mem[m_addr] : m_addr) : 16'hDEAD;
        p1 <= p0;
        if (m_wr && !m_stall) mem[m_addr] = m_data_in;
    end

    typedef struct {bit err; bit hit; bit chk; logic [15:0] d; int cyc;} exp_t;
    typedef struct {bit wr; logic [15:0] a; logic [15:0] d;} mop_t;
    exp_t q[$];
    mop_t mq[$];

    always @(negedge clk) begin : mon_done
        exp_t e;
        if (!rst && Done) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: got Done=1 at cycle %0d, want no completion", cyc);
            end else begin
                e = q.pop_front();
                if (Err !== e.err || CacheHit !== e.hit || (e.chk && DataOut !== e.d) ||
                    cyc != e.cyc || Stall !== (e.cyc != 0 && !e.err && !e.hit) ||
                    (e.err && (c_enable || c_write || m_rd || m_wr))) begin
                    errors++;
                    $display("FAIL done_resp: got err=%0b hit=%0b data=%h cyc=%0d stall=%0b act=%0b, want err=%0b hit=%0b data=%h cyc=%0d",
                             Err, CacheHit, DataOut, cyc, Stall, c_enable | c_write | m_rd | m_wr,
                             e.err, e.hit, e.d, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_mem
        mop_t e;
        if (!rst && (m_rd || m_wr) && !m_stall) begin
            checks++;
            if (mq.size() == 0) begin
                errors++;
                $display("FAIL mem_unexpected: got wr=%0b addr=%h", m_wr, m_addr);
            end else begin
                e = mq.pop_front();
                if (m_wr !== e.wr || m_rd !== !e.wr || m_addr !== e.a || (e.wr && m_data_in !== e.d)) begin
                    errors++;
                    $display("FAIL mem_op: got wr=%0b addr=%h data=%h, want wr=%0b addr=%h data=%h",
                             m_wr, m_addr, m_data_in, e.wr, e.a, e.d);
                end
            end
        end
    end

    task automatic push_mem(input bit wr, input logic [15:0] base, input logic [15:0] d0);
        mop_t m;
        for (int k = 0; k < 4; k++) begin
            m.wr = wr; m.a = base + 16'(2 * k); m.d = d0 + 16'(k);
            mq.push_back(m);
        end
    endtask

    task automatic access(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d,
                          input bit e_err, input bit e_hit, input bit e_chk, input logic [15:0] e_d,
                          input int lat, input int stl);
        exp_t x;
        bit seen;
        @(posedge clk); #1;
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        x.err = e_err; x.hit = e_hit; x.chk = e_chk; x.d = e_d; x.cyc = cyc + lat;
        q.push_back(x);
        if (stl >= 0) begin st_lo = cyc + stl; st_hi = cyc + stl + 2; end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = Done;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no Done for addr %h within 40 cycles, want Done", a);
        end
        @(posedge clk); #1;
        Rd = 1'b0; Wr = 1'b0;
    endtask

    task automatic chk_quiet(input string name);
        checks++;
        if ({Done, Stall, Err, CacheHit, c_enable, c_comp, c_write, c_valid_in, m_rd, m_wr} !== '0 ||
            DataOut !== '0 || m_addr !== '0 || m_data_in !== '0 || c_index !== '0 ||
            c_offset !== '0 || c_tag_in !== '0 || c_data_in !== '0) begin
            errors++;
            $display("FAIL %s: got ctl=%b DataOut=%h m_addr=%h c_index=%h, want all zero", name,
                     {Done, Stall, Err, CacheHit, c_enable, c_comp, c_write, c_valid_in, m_rd, m_wr},
                     DataOut, m_addr, c_index);
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [4:0] t, input bit dirty, input logic [15:0] d);
        @(posedge clk); #1;
        pre_en = 1'b1; pre_idx = idx; pre_tag = t; pre_dirty = dirty; pre_d = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    initial begin
        int fw0;
        rst = 1'b1; Rd = 1'b1; Wr = 1'b0; Addr = 16'h0080; DataIn = 16'h5555;
        arr_clr = 1'b1; pre_en = 1'b0; pre_dirty = 1'b0; pre_idx = '0; pre_tag = '0; pre_d = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset_outputs");
        @(posedge clk); #1;
        rst = 1'b0; Rd = 1'b0; arr_clr = 1'b0;
        preload(8'h10, 5'h00, 1'b0, 16'hA000);
        preload(8'h20, 5'h03, 1'b1, 16'hD000);

        access(1, 0, 16'h0080, 0, 0, 1, 1, 16'hA000, 0, -1);
        push_mem(0, 16'h1230, 0);
        access(1, 0, 16'h1234, 0, 0, 0, 1, 16'h1234, 7, -1);
        push_mem(1, 16'h1900, 16'hD000);
        push_mem(0, 16'h2900, 0);
        access(0, 1, 16'h2902, 16'hBEEF, 0, 0, 0, 16'h0000, 11, -1);
        access(1, 0, 16'h2902, 0, 0, 1, 1, 16'hBEEF, 0, -1);
        access(1, 0, 16'h2900, 0, 0, 1, 1, 16'h2900, 0, -1);

        push_mem(0, 16'h3040, 0);
        fw0 = fill_wr;
        access(1, 0, 16'h3046, 0, 0, 0, 1, 16'h3046, 10, 2);
        checks++;
        if (fill_wr - fw0 != 4) begin
            errors++;
            $display("FAIL fill_writes: got %0d return writes, want 4", fill_wr - fw0);
        end
        for (int k = 0; k < 4; k++)
            access(1, 0, 16'h3040 + 16'(2 * k), 0, 0, 1, 1, 16'h3040 + 16'(2 * k), 0, -1);

        access(1, 1, 16'h0080, 0, 1, 0, 0, 0, 0, -1);
        access(1, 0, 16'h0001, 0, 1, 0, 0, 0, 0, -1);

        mq.push_back('{wr: 1'b0, a: 16'h4000, d: 16'h0});
        mq.push_back('{wr: 1'b0, a: 16'h4002, d: 16'h0});
        @(posedge clk); #1;
        Rd = 1'b1; Addr = 16'h4000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1; Rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("reset_in_fill");
        repeat (4) @(posedge clk);

        push_mem(0, 16'h4000, 0);
        access(1, 0, 16'h4000, 0, 0, 0, 1, 16'h4000, 7, -1);
        push_mem(0, 16'h5008, 0);
        access(1, 0, 16'h500C, 0, 0, 0, 1, 16'h500C, 7, -1);
        access(1, 0, 16'h4002, 0, 0, 1, 1, 16'h4002, 0, -1);
        access(1, 0, 16'h500E, 0, 0, 1, 1, 16'h500E, 0, -1);
        access(1, 0, 16'h0080, 0, 0, 1, 1, 16'hA000, 0, -1);
`ifdef CACHE_CTRL_STATS_EN
        @(negedge clk);
        checks++;
        if (hit_cnt !== 16'd3 || miss_cnt !== 16'd2) begin
            errors++;
            $display("FAIL stats: got hit_cnt=%0d miss_cnt=%0d, want 3 and 2", hit_cnt, miss_cnt);
        end
`endif
        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0 || mq.size() != 0) begin
            errors++;
            $display("FAIL leftovers: got %0d responses and %0d memory ops pending, want 0 and 0",
                     q.size(), mq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
